// File: rtl/axi4_read_arbiter_if.sv
// AXI4 read-channel bundle (AR + R) shared by the arbiter's requester
// ports and its single master port.
//   master modport : drives AR payload/valid and R ready
//   slave modport  : drives AR ready and the R beat
// ID_W differs between requester side (AXI_ID_WIDTH) and master side
// (AXI_ID_WIDTH+1, MSB carries the source tag).
interface axi4_read_arbiter_if #(
    parameter int ID_W   = 6,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic [ID_W-1:0]   arid;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              arvalid;
    logic              arready;

    logic [ID_W-1:0]   rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid, rready,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
        output arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/axi4_read_arbiter.sv
// Two-requester AXI4 read arbiter: round-robins AR requests from s0/s1 onto
// one master port, tags each with its source in the ID MSB, steers R beats
// back by that tag and caps outstanding bursts per requester.
//   aclk     : clock
//   aresetn  : synchronous active-low reset
//   s0, s1   : requester read channels (arbiter acts as their slave)
//   m        : shared read channel toward the memory slave
//
// state | meaning
// IDLE  | arbitrate; one eligible requester sees arready and is accepted
// ISSUE | m_arvalid held with stable payload until m_arready
module axi4_read_arbiter #(
    parameter int AXI_ID_WIDTH    = 6,
    parameter int AXI_ADDR_WIDTH  = 32,
    parameter int AXI_DATA_WIDTH  = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    axi4_read_arbiter_if.slave   s0,
    axi4_read_arbiter_if.slave   s1,
    axi4_read_arbiter_if.master  m
);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    typedef enum logic [0:0] {IDLE, ISSUE} state_t;

    state_t                    state_q, state_d;
    logic                      last_q, last_d;
    logic [CNT_W-1:0]          cnt0_q, cnt0_d;
    logic [CNT_W-1:0]          cnt1_q, cnt1_d;
    logic                      arvalid_q, arvalid_d;
    logic [AXI_ID_WIDTH:0]     arid_q, arid_d;
    logic [AXI_ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [7:0]                arlen_q, arlen_d;
    logic [2:0]                arsize_q, arsize_d;
    logic [1:0]                arburst_q, arburst_d;

    logic elig0, elig1, sel_src, grant0, grant1;
    logic src, rready_w, dec0, dec1;

    // Arbitration: on a tie the requester not granted last wins; with a
    // single eligible requester it wins regardless of last_q.
    always_comb begin
        elig0   = s0.arvalid && (cnt0_q < CNT_MAX);
        elig1   = s1.arvalid && (cnt1_q < CNT_MAX);
        sel_src = (elig0 && elig1) ? ~last_q : elig1;
        grant0  = (state_q == IDLE) && aresetn && elig0 && !sel_src;
        grant1  = (state_q == IDLE) && aresetn && elig1 && sel_src;
    end

    assign s0.arready = grant0;
    assign s1.arready = grant1;

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        arvalid_d = arvalid_q;
        arid_d    = arid_q;
        araddr_d  = araddr_q;
        arlen_d   = arlen_q;
        arsize_d  = arsize_q;
        arburst_d = arburst_q;
        case (state_q)
            IDLE: begin
                if (grant0 || grant1) begin
                    state_d   = ISSUE;
                    arvalid_d = 1'b1;
                    last_d    = sel_src;
                    if (sel_src) begin
                        arid_d    = {1'b1, s1.arid};
                        araddr_d  = s1.araddr;
                        arlen_d   = s1.arlen;
                        arsize_d  = s1.arsize;
                        arburst_d = s1.arburst;
                    end else begin
                        arid_d    = {1'b0, s0.arid};
                        araddr_d  = s0.araddr;
                        arlen_d   = s0.arlen;
                        arsize_d  = s0.arsize;
                        arburst_d = s0.arburst;
                    end
                end
            end
            ISSUE: begin
                if (m.arready) begin
                    arvalid_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign m.arid    = arid_q;
    assign m.araddr  = araddr_q;
    assign m.arlen   = arlen_q;
    assign m.arsize  = arsize_q;
    assign m.arburst = arburst_q;
    assign m.arvalid = arvalid_q;

    // R path: purely combinational steering on the source tag.
    assign src      = m.rid[AXI_ID_WIDTH];
    assign rready_w = src ? s1.rready : s0.rready;
    assign m.rready = rready_w;

    assign s0.rid    = m.rid[AXI_ID_WIDTH-1:0];
    assign s0.rdata  = m.rdata;
    assign s0.rresp  = m.rresp;
    assign s0.rlast  = m.rlast;
    assign s0.rvalid = m.rvalid && !src;

    assign s1.rid    = m.rid[AXI_ID_WIDTH-1:0];
    assign s1.rdata  = m.rdata;
    assign s1.rresp  = m.rresp;
    assign s1.rlast  = m.rlast;
    assign s1.rvalid = m.rvalid && src;

    assign dec0 = m.rvalid && rready_w && m.rlast && !src;
    assign dec1 = m.rvalid && rready_w && m.rlast && src;

    // Eligibility keeps the increment away from CNT_MAX, so no wrap check.
    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        case ({grant0, dec0})
            2'b10:   cnt0_d = cnt0_q + CNT_W'(1);
            2'b01:   cnt0_d = cnt0_q - CNT_W'(1);
            default: cnt0_d = cnt0_q;
        endcase
        case ({grant1, dec1})
            2'b10:   cnt1_d = cnt1_q + CNT_W'(1);
            2'b01:   cnt1_d = cnt1_q - CNT_W'(1);
            default: cnt1_d = cnt1_q;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            cnt0_q    <= '0;
            cnt1_q    <= '0;
            arvalid_q <= 1'b0;
            arid_q    <= '0;
            araddr_q  <= '0;
            arlen_q   <= '0;
            arsize_q  <= '0;
            arburst_q <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            cnt0_q    <= cnt0_d;
            cnt1_q    <= cnt1_d;
            arvalid_q <= arvalid_d;
            arid_q    <= arid_d;
            araddr_q  <= araddr_d;
            arlen_q   <= arlen_d;
            arsize_q  <= arsize_d;
            arburst_q <= arburst_d;
        end
    end
endmodule

// File: doc/axi4_read_arbiter.md
# axi4_read_arbiter

Two-requester AXI4 read-channel arbiter that shares one AXI4 read port, such as the PS memory port mem00, between two masters, for example a video frame-buffer reader and a second DMA. It round-robins AR requests and tags each with its source in the ID MSB. It steers R beats back by that tag and limits outstanding bursts per requester. Write channels bypass this block.

## Interface
Parameters:
- AXI_ID_WIDTH, 6, requester ID width; the master-side ID is AXI_ID_WIDTH+1 bits.
- AXI_ADDR_WIDTH, 32, address width.
- AXI_DATA_WIDTH, 32, data width.
- MAX_OUTSTANDING, 4, maximum number of accepted-but-incomplete bursts per requester (1..15).

Ports (N ∈ {0,1}; one line per port group):
- aclk  in  1  single clock for all logic.
- aresetn  in  1  synchronous, active-low reset.
- sN_ar{id,addr,len,size,burst}  in  AXI_ID_WIDTH/AXI_ADDR_WIDTH/8/3/2  requester N AR payload.
- sN_arvalid  in  1  requester N AR valid.
- sN_arready  out  1  requester N AR accepted.
- sN_rid  out  AXI_ID_WIDTH  m_rid[AXI_ID_WIDTH-1:0].
- sN_r{data,resp,last}  out  AXI_DATA_WIDTH/2/1  broadcast copies of m_r{data,resp,last}.
- sN_rvalid  out  1  R beat valid for requester N.
- sN_rready  in  1  requester N R ready.
- m_ar{id,addr,len,size,burst}  out  AXI_ID_WIDTH+1/AXI_ADDR_WIDTH/8/3/2  registered AR payload; m_arid = {src, sN_arid}.
- m_arvalid  out  1  AR valid to slave.
- m_arready  in  1  slave AR ready.
- m_rid  in  AXI_ID_WIDTH+1  slave R ID; MSB is the source tag.
- m_r{data,resp,last}  in  AXI_DATA_WIDTH/2/1  slave R beat.
- m_rvalid  in  1  slave R valid.
- m_rready  out  1  R ready to slave.

## Operation
- State machine with two states:
  - IDLE: accepts a request.
  - ISSUE: holds m_arvalid until the slave takes the request.
- Eligibility: requester N is eligible when sN_arvalid=1 and outstanding count cnt_N < MAX_OUTSTANDING.
- Arbitration in IDLE:
  - Round-robin; the requester not granted last has priority.
  - The last-granted register resets to 1, so s0 wins the first tie.
  - The last-granted register updates only on an accept.
- sN_arready is combinational: 1 only in IDLE, with aresetn=1, when N is the selected eligible requester.
- Accept (sN_arvalid & sN_arready):
  - Latch the payload into the m_ar* registers, with m_arid = {N, sN_arid}.
  - Set m_arvalid=1.
  - Increment cnt_N.
  - Go to ISSUE.
- ISSUE: m_ar* and m_arvalid stay stable until m_arready=1, then m_arvalid=0 and the state returns to IDLE. sN_arready=0 for both requesters throughout ISSUE.
- R routing:
  - src = m_rid[AXI_ID_WIDTH].
  - sN_rvalid = m_rvalid & (src==N).
  - m_rready = sN_rready of requester src.
  - Data, resp and last are broadcast to both requesters; rresp passes through unmodified.
- cnt_N decrements on m_rvalid & m_rready & m_rlast & src==N.
  - Increment and decrement in the same cycle leave cnt_N unchanged.
  - Counter width is clog2(MAX_OUTSTANDING+1); cnt_N never wraps, because eligibility blocks an increment at MAX and a decrement at 0 cannot occur with a legal slave.
- Burst interleaving between sources on R is allowed and routed beat by beat.

## Timing
- Reset values (when aresetn=0 at a clock edge):
  - State IDLE, m_arvalid=0, m_ar* all 0, cnt_0=cnt_1=0, last-granted=1.
  - sN_arready is forced to 0 while aresetn=0.
- Reset mid-operation abandons the pending AR and all outstanding counts. The slave must be reset in the same cycle.
- AR latency: accept at cycle t gives m_arvalid=1 at t+1.
- AR throughput: at most one AR per 2 cycles (accept in IDLE, issue in ISSUE with m_arready=1). Each extra cycle of m_arready=0 adds one cycle.
- R path is fully combinational: zero latency, no buffering, full throughput.
- Simultaneous eligible requests in IDLE: exactly one sN_arready is asserted, per round-robin.

## Test plan
- s0 request, arid=5, araddr=0x1000, len=15; m_arready=1 → s0_arready at t, m_arvalid at t+1 with m_arid=0x05. 16 beats with m_rid=0x05 are seen only on s0_rvalid; cnt_0 returns 0 after rlast.
- Both requesters hold arvalid continuously, slave always ready → grant order s0, s1, s0, s1. s1 gets m_arid MSB=1 (0x40|id); one AR every 2 cycles.
- MAX_OUTSTANDING=2, s0 issues 3 requests, no R returned → third s0_arready stays 0 while s1 is still granted. After one s0 rlast, the third s0 request is accepted on the next IDLE cycle.
- m_arready held 0 for 5 cycles after issue → m_arvalid and m_ar* stay stable, no sN_arready, then IDLE after the handshake.
- R beats alternate m_rid MSB 0/1, s1_rready=0 → m_rready=0 on s1 beats and 1 on s0 beats; s0 completes its burst while s1 stalls.
- aresetn=0 during ISSUE with cnt_0=3 → next cycle m_arvalid=0, counters 0, first post-reset tie goes to s0.
